// File: rtl/stream_fifo.sv
// First-word-fall-through FIFO between a valid/ready stream producer and consumer.
// The head word is read combinationally from storage; fill and almost_full are registered.
module stream_fifo #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 16,
  parameter int ALMOST_FULL = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH-1:0]             stream_s_data_i,
  input  logic                         stream_s_valid_i,
  output logic                         stream_s_ready_o,
  output logic [WIDTH-1:0]             stream_m_data_o,
  output logic                         stream_m_valid_o,
  input  logic                         stream_m_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   fill_o,
  output logic                         almost_full_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW = $clog2(DEPTH + 1);
  localparam logic [FW-1:0] FULL_LVL = FW'(DEPTH);
  localparam logic [FW-1:0] AF_LVL   = FW'(ALMOST_FULL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [FW-1:0]    fill;
  logic [FW-1:0]    fill_next;
  logic             not_full;
  logic             wr_en;
  logic             rd_en;
  logic             almost_full_q;

  // Ready depends only on stored state and reset, never on the consumer's ready.
  assign not_full         = (fill != FULL_LVL);
  assign stream_s_ready_o = rst_n && not_full;
  assign stream_m_valid_o = (fill != '0);
  assign stream_m_data_o  = mem[rd_ptr];
  assign fill_o           = fill;
  assign almost_full_o    = almost_full_q;

  assign wr_en = stream_s_valid_i && not_full;
  assign rd_en = stream_m_valid_o && stream_m_ready_i;

  always_comb begin
    fill_next = fill;
    case ({wr_en, rd_en})
      2'b10:   fill_next = fill + FW'(1);
      2'b01:   fill_next = fill - FW'(1);
      default: fill_next = fill;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fill          <= '0;
      almost_full_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      fill          <= fill_next;
      almost_full_q <= (fill_next >= AF_LVL);
    end
  end

  // Storage is not reset; a write during reset is harmless because wr_ptr and fill stay cleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= stream_s_data_i;
  end

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo with WIDTH=8, DEPTH=4, ALMOST_FULL=3.
// Each scenario task drives its own stimulus and compares against hand-computed values.
module tb_stream_fifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [2:0] fill;
  logic       almost_full;

  int n_cmp = 0;
  int n_err = 0;

  stream_fifo #(.WIDTH(8), .DEPTH(4), .ALMOST_FULL(3)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stream_s_data_i  (s_data),
    .stream_s_valid_i (s_valid),
    .stream_s_ready_o (s_ready),
    .stream_m_data_o  (m_data),
    .stream_m_valid_o (m_valid),
    .stream_m_ready_i (m_ready),
    .fill_o           (fill),
    .almost_full_o    (almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;
    #2;
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_valid got %b want 0", m_valid); end
    n_cmp++; if (fill !== 3'd0) begin n_err++; $display("[TB] FAIL reset_fill got %0d want 0", fill); end
    n_cmp++; if (almost_full !== 1'b0) begin n_err++; $display("[TB] FAIL reset_af got %b want 0", almost_full); end
    n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("[TB] FAIL reset_ready got %b want 0", s_ready); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("[TB] FAIL release_ready got %b want 1", s_ready); end
  endtask

  task automatic test_single_word();
    s_valid = 1'b1; s_data = 8'h11; m_ready = 1'b1;
    tick();
    s_valid = 1'b0; s_data = 8'hEE;
    n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("[TB] FAIL single_valid got %b want 1", m_valid); end
    n_cmp++; if (m_data !== 8'h11) begin n_err++; $display("[TB] FAIL single_data got %h want 11", m_data); end
    n_cmp++; if (fill !== 3'd1) begin n_err++; $display("[TB] FAIL single_fill1 got %0d want 1", fill); end
    tick();
    n_cmp++; if (fill !== 3'd0) begin n_err++; $display("[TB] FAIL single_fill0 got %0d want 0", fill); end
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("[TB] FAIL single_empty got %b want 0", m_valid); end
    m_ready = 1'b0;
  endtask

  task automatic test_fill_drain();
    logic [7:0] exp_d;
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 8'hA0 + 8'(i);
      tick();
      n_cmp++; if (fill !== 3'(i + 1)) begin n_err++; $display("[TB] FAIL fd_fill%0d got %0d want %0d", i, fill, i + 1); end
      n_cmp++; if (almost_full !== (i + 1 >= 3)) begin n_err++; $display("[TB] FAIL fd_af%0d got %b want %b", i, almost_full, (i + 1 >= 3)); end
      n_cmp++; if (s_ready !== (i < 3)) begin n_err++; $display("[TB] FAIL fd_ready%0d got %b want %b", i, s_ready, (i < 3)); end
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_d = 8'hA0 + 8'(i);
      n_cmp++; if (m_valid !== 1'b1 || m_data !== exp_d) begin n_err++; $display("[TB] FAIL fd_drain%0d got v=%b d=%h want v=1 d=%h", i, m_valid, m_data, exp_d); end
      tick();
    end
    n_cmp++; if (fill !== 3'd0 || almost_full !== 1'b0) begin n_err++; $display("[TB] FAIL fd_end got fill=%0d af=%b want 0/0", fill, almost_full); end
    m_ready = 1'b0;
  endtask

  task automatic test_full_simultaneous();
    logic [7:0] exp_q [4];
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 8'hB0 + 8'(i);
      tick();
    end
    s_data = 8'hC0; m_ready = 1'b1;
    n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("[TB] FAIL full_ready got %b want 0", s_ready); end
    tick();
    m_ready = 1'b0;
    n_cmp++; if (fill !== 3'd3) begin n_err++; $display("[TB] FAIL full_fill3 got %0d want 3", fill); end
    n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("[TB] FAIL full_ready_next got %b want 1", s_ready); end
    n_cmp++; if (m_data !== 8'hB1) begin n_err++; $display("[TB] FAIL full_head got %h want b1", m_data); end
    tick();
    s_valid = 1'b0;
    n_cmp++; if (fill !== 3'd4) begin n_err++; $display("[TB] FAIL full_refill got %0d want 4", fill); end
    exp_q = '{8'hB1, 8'hB2, 8'hB3, 8'hC0};
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (m_valid !== 1'b1 || m_data !== exp_q[i]) begin n_err++; $display("[TB] FAIL full_drain%0d got v=%b d=%h want v=1 d=%h", i, m_valid, m_data, exp_q[i]); end
      tick();
    end
    m_ready = 1'b0;
  endtask

  task automatic test_wrap_random();
    int wr_idx = 0;
    int rd_idx = 0;
    int cycles = 0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    while (rd_idx < 32 && cycles < 2000) begin
      if (!(s_valid && !s_ready)) begin
        s_valid = (wr_idx < 32) && ($urandom_range(1, 0) == 1);
        s_data  = 8'(wr_idx);
      end
      m_ready = ($urandom_range(1, 0) == 1);
      if (m_valid && m_ready) begin
        n_cmp++;
        if (m_data !== 8'(rd_idx)) begin n_err++; $display("[TB] FAIL wrap_word%0d got %h want %h", rd_idx, m_data, 8'(rd_idx)); end
        rd_idx++;
      end
      if (s_valid && s_ready) wr_idx++;
      tick();
      cycles++;
    end
    s_valid = 1'b0; m_ready = 1'b0;
    n_cmp++; if (rd_idx !== 32) begin n_err++; $display("[TB] FAIL wrap_count got %0d want 32", rd_idx); end
    n_cmp++; if (fill !== 3'd0) begin n_err++; $display("[TB] FAIL wrap_fill got %0d want 0", fill); end
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 8'h5A; tick();
    s_data = 8'h5B; tick();
    s_valid = 1'b0;
    n_cmp++; if (fill !== 3'd2) begin n_err++; $display("[TB] FAIL mid_prefill got %0d want 2", fill); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("[TB] FAIL mid_valid got %b want 0", m_valid); end
    n_cmp++; if (fill !== 3'd0) begin n_err++; $display("[TB] FAIL mid_fill got %0d want 0", fill); end
    n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("[TB] FAIL mid_ready got %b want 0", s_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++; if (m_valid !== 1'b0 || fill !== 3'd0 || s_ready !== 1'b1) begin n_err++; $display("[TB] FAIL mid_after got v=%b fill=%0d rdy=%b want 0/0/1", m_valid, fill, s_ready); end
  endtask

  task automatic test_back_pressure();
    logic [7:0] exp_d;
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 8'hD0;
    tick();
    for (int i = 1; i <= 10; i++) begin
      s_data = 8'hD0 + 8'(i);
      n_cmp++; if (m_valid !== 1'b1 || m_data !== 8'hD0) begin n_err++; $display("[TB] FAIL bp_hold%0d got v=%b d=%h want v=1 d=d0", i, m_valid, m_data); end
      tick();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_d = 8'hD0 + 8'(i);
      n_cmp++; if (m_data !== exp_d) begin n_err++; $display("[TB] FAIL bp_drain%0d got %h want %h", i, m_data, exp_d); end
      tick();
    end
    n_cmp++; if (fill !== 3'd0) begin n_err++; $display("[TB] FAIL bp_end got %0d want 0", fill); end
    m_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_fill_drain();
    test_full_simultaneous();
    test_wrap_random();
    test_reset_mid();
    test_back_pressure();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
